// File: rtl/imem_loader.sv
// Boot-time loader: packs a little-endian byte stream into 32-bit words and writes
// them sequentially into the instruction store while holding the core in reset-like stall.
module imem_loader #(
    parameter int DEPTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic             core_hold,
    output logic             load_done,
    output logic             load_err,
    output logic [CNT_W-1:0] word_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      asm_q, asm_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic             core_hold_q, core_hold_d;
    logic             load_done_q, load_done_d;
    logic             load_err_q, load_err_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;

    logic        hs;
    logic        word_end;
    logic        start_load;
    logic [31:0] merged;

    // Valid/ready: a byte moves only on a clock edge where in_valid and in_ready are both 1;
    // in_ready depends on state alone, so the source may hold in_valid/in_data until accepted.
    assign in_ready   = (state_q == S_LOAD);
    assign hs         = in_valid & in_ready;
    assign merged     = asm_q | (32'(in_data) << {byte_idx_q, 3'b000});
    assign word_end   = hs & ((byte_idx_q == 2'd3) | in_last);
    assign start_load = start & (state_q != S_LOAD);

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        core_hold_d  = core_hold_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;
        word_count_d = word_count_q;

        if (state_q == S_LOAD && hs) begin
            byte_idx_d = byte_idx_q + 2'd1;
            asm_d      = merged;
            if (word_end) begin
                asm_d = 32'h0;
                // Store full: keep draining the stream but drop the word.
                if (word_count_q == CNT_W'(DEPTH)) begin
                    load_err_d = 1'b1;
                end else begin
                    wr_en_d      = 1'b1;
                    wr_addr_d    = 32'({word_count_q, 2'b00});
                    wr_data_d    = merged;
                    word_count_d = word_count_q + 1'b1;
                end
            end
            if (in_last) begin
                state_d     = S_DONE;
                byte_idx_d  = 2'd0;
                load_done_d = 1'b1;
                core_hold_d = 1'b0;
            end
        end

        if (start_load) begin
            state_d      = S_LOAD;
            byte_idx_d   = 2'd0;
            asm_d        = 32'h0;
            word_count_d = '0;
            load_done_d  = 1'b0;
            load_err_d   = 1'b0;
            core_hold_d  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= 2'd0;
            asm_q        <= 32'h0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 32'h0;
            wr_data_q    <= 32'h0;
            core_hold_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            core_hold_q  <= core_hold_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
            word_count_q <= word_count_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign core_hold  = core_hold_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign word_count = word_count_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side companion to the instruction cache. It accepts a byte stream (valid/ready) from a boot source such as a UART receiver or debug port. Bytes are packed little-endian into 32-bit instruction words and written sequentially into the instruction store starting at byte address 0. While a load is in progress, the loader holds the core via core_hold, and it releases the core when the load completes.

Parameters:
DEPTH, 32, number of 32-bit words in the instruction store; writes beyond it are dropped
CNT_W, 6, width of word_count; must satisfy CNT_W >= clog2(DEPTH)+1

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  single-cycle pulse; begins a new load
in_valid  in  1  byte available on in_data
in_data  in  8  stream byte
in_last  in  1  marks the final byte of the image; qualified by in_valid
in_ready  out  1  loader accepts a byte this cycle
wr_en  out  1  one-cycle write strobe to the instruction store
wr_addr  out  32  byte address of the write; always a multiple of 4 (store index = wr_addr/4)
wr_data  out  32  instruction word
core_hold  out  1  keeps fetch/core stalled while 1
load_done  out  1  image completely written; sticky until next start
load_err  out  1  image exceeded DEPTH words; sticky until next start
word_count  out  CNT_W  words written so far

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; byte_idx=0; assembly register=0.
  - wr_en=0, wr_addr=0, wr_data=0, in_ready=0, load_done=0, load_err=0, word_count=0.
  - core_hold=1: the core never runs unloaded code.
- States: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start=1 -> LOAD. On entry: clear byte_idx, assembly register, word_count, load_done and load_err.
- LOAD:
  - in_ready=1 combinationally in this state.
  - Handshake = in_valid & in_ready. Each accepted byte goes to lane byte_idx (bits 8*byte_idx+7 : 8*byte_idx); byte_idx then increments mod 4.
  - A word completes when the accepted byte has byte_idx==3, or when in_last=1 with any byte_idx.
    - Unwritten upper lanes are 0, because the assembly register clears after every completed word.
  - Write latency: wr_en=1 in the cycle after the completing handshake, for exactly one cycle.
    - wr_addr = 4*word_count (pre-increment value); wr_data = assembled word.
    - word_count increments in the same cycle as that wr_en.
  - Back-to-back: a new byte may be accepted in the same cycle wr_en is asserted.
  - Overflow: if a word completes while word_count==DEPTH:
    - no wr_en; word_count holds at DEPTH; load_err=1.
    - Bytes continue to be accepted and discarded until in_last.
  - in_last accepted -> DONE (after the final word's wr_en, which occurs in the first DONE cycle).
  - start during LOAD is ignored.
- DONE:
  - in_ready=0; load_done=1; core_hold=0.
  - start=1 -> LOAD with the same entry clears; core_hold=1 and load_done=0 from the next cycle.
- core_hold = 1 in IDLE and LOAD, 0 only in DONE.
- Reset during LOAD:
  - Partial word discarded; no wr_en is issued afterwards; core_hold=1.
  - Words already written stay in the store, but word_count reads 0.
- Simultaneous start and reset==0: reset wins.
- Zero-length image is not possible, since in_last requires a byte. A single byte with in_last produces one write of {24'h0, byte}.
- All outputs except in_ready are registered.

Test Plan:
- Two full words: start, then bytes 93 00 80 3e 13 81 00 7d, in_last on the 8th, in_valid held high -> wr_en pulses with (addr 0x0, data 0x3e800093) then (addr 0x4, data 0x7d008113). The second pulse is 1 cycle after the 8th handshake. Then load_done=1, core_hold=0, word_count=2, load_err=0.
- Partial final word: bytes 93 00 80 3e aa, in_last on aa -> writes (0x0, 0x3e800093) and (0x4, 0x000000aa); word_count=2.
- Gaps and idle: toggle in_valid randomly during LOAD; drive in_valid=1 with data 0xff in IDLE and DONE -> identical writes to the first scenario; no byte is accepted outside LOAD (in_ready=0).
- Overflow with DEPTH=32: send 33 words (132 bytes), in_last on byte 132 -> exactly 32 wr_en pulses; last write at addr 0x7c; load_err=1, load_done=1, word_count=32.
- Reset mid-load: assert reset==0 for one cycle after 6 bytes -> IDLE, core_hold=1, no wr_en for bytes 5-6. A following start plus 4 bytes writes to addr 0x0.
- Reload: from DONE, pulse start -> next cycle core_hold=1, load_done=0, word_count=0. A new 4-byte image writes addr 0x0; start pulses asserted mid-LOAD have no effect.
